// File: rtl/token_multiplier.sv
// token_multiplier
// Serial token rate multiplier. Each '1' token sampled on `a` owes FACTOR
// output '1's on `b`. One owed token is emitted per cycle. Owed tokens that
// are not yet emitted accumulate in a backlog counter.
// `hold` stalls emission. New tokens are still accepted while `hold` is high.
// If the backlog would exceed its capacity, a sticky overflow flag is set.
//
// Optional build macro:
//   TOKEN_MULTIPLIER_HALT_ON_OVERFLOW_EN
//     undefined : on overflow the backlog saturates and emission continues
//     defined   : on overflow the backlog is cleared and the block goes
//                 silent (b=0, backlog=0) until rst
module token_multiplier #(
   parameter int FACTOR  = 2,
   parameter int MAX_RUN = 200
) (
   input  logic                                                clk,
   input  logic                                                rst,
   input  logic                                                a,
   input  logic                                                hold,
   output logic                                                b,
   output logic                                                overflow,
   output logic [$clog2(MAX_RUN*(FACTOR-1)+FACTOR+1)-1:0]       backlog,
   output logic                                                idle
);

   localparam int BACKLOG_MAX = MAX_RUN * (FACTOR - 1);
   localparam int CW          = $clog2(BACKLOG_MAX + FACTOR + 1);

   localparam logic [CW-1:0] CAP = CW'(BACKLOG_MAX);
   localparam logic [CW-1:0] FAC = CW'(FACTOR);

   logic          emit;
   logic [CW-1:0] sum;

   // Next-cycle emission decision and the backlog after this cycle's add/subtract.
   // NOTE: every combinational output gets a default first, so no path can leave it unassigned and infer a latch.
   always_comb begin
      emit = 1'b0;
      sum  = '0;
      emit = !hold && (a || (backlog != '0));
      // Emission implies a || backlog != 0, so the subtraction never underflows.
      // backlog + FACTOR fits in CW bits by the choice of CW.
      sum  = backlog + (a ? FAC : '0) - CW'(emit);
   end

   // Backlog counter, registered output token, and sticky overflow flag.
   // NOTE: state registers use non-blocking assignments so that every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         b        <= 1'b0;
         overflow <= 1'b0;
         backlog  <= '0;
      end else begin
`ifdef TOKEN_MULTIPLIER_HALT_ON_OVERFLOW_EN
         if (overflow) begin
            // Halted: ignore a/hold and stay silent until reset.
            b       <= 1'b0;
            backlog <= '0;
         end else if (sum > CAP) begin
            // Offending token: drop all owed tokens and stop emitting.
            overflow <= 1'b1;
            backlog  <= '0;
            b        <= 1'b0;
         end else begin
            backlog <= sum;
            b       <= emit;
         end
`else
         b <= emit;
         if (sum > CAP) begin
            // Excess tokens are lost. The backlog pins at capacity.
            overflow <= 1'b1;
            backlog  <= CAP;
         end else begin
            backlog <= sum;
         end
`endif
      end
   end

   // Idle status comes straight from the registered backlog, with no path from a/hold.
   assign idle = (backlog == '0);

endmodule

// File: tb/tb_token_multiplier.sv
// tb_token_multiplier
// Three instances share the same a/hold/rst stimulus:
//   FACTOR=2 MAX_RUN=200, FACTOR=3 MAX_RUN=5, FACTOR=1 MAX_RUN=200.
// The reference model keeps an owed-token count per instance.
// Inputs are driven before each posedge. Outputs are sampled on the negedge.
module tb_token_multiplier;

   logic clk = 1'b0;
   logic rst, a, hold;

   logic       b_f2, ov_f2, idle_f2;
   logic [7:0] bl_f2;
   logic       b_f3, ov_f3, idle_f3;
   logic [3:0] bl_f3;
   logic       b_f1, ov_f1, idle_f1;
   logic [0:0] bl_f1;

   always #5 clk = ~clk;

   token_multiplier #(.FACTOR(2), .MAX_RUN(200)) dut_f2 (
      .clk(clk), .rst(rst), .a(a), .hold(hold),
      .b(b_f2), .overflow(ov_f2), .backlog(bl_f2), .idle(idle_f2));

   token_multiplier #(.FACTOR(3), .MAX_RUN(5)) dut_f3 (
      .clk(clk), .rst(rst), .a(a), .hold(hold),
      .b(b_f3), .overflow(ov_f3), .backlog(bl_f3), .idle(idle_f3));

   token_multiplier #(.FACTOR(1), .MAX_RUN(200)) dut_f1 (
      .clk(clk), .rst(rst), .a(a), .hold(hold),
      .b(b_f1), .overflow(ov_f1), .backlog(bl_f1), .idle(idle_f1));

   int errors = 0;
   int checks = 0;

   // Reference model: owed tokens, expected b, and expected overflow per instance.
   int fac[3] = '{2, 3, 1};
   int cap[3] = '{200, 10, 0};
   int owed[3];
   int mb[3];
   int mov[3];

   // Sampled DUT outputs, indexed like the model.
   int gb[3], go[3], gl[3], gi[3];

   task automatic model_edge(input logic ia, input logic ih, input logic ir);
      for (int k = 0; k < 3; k++) begin
         int t;
         int e;
         if (ir) begin
            owed[k] = 0; mb[k] = 0; mov[k] = 0;
         end
`ifdef TOKEN_MULTIPLIER_HALT_ON_OVERFLOW_EN
         else if (mov[k] != 0) begin
            owed[k] = 0; mb[k] = 0;
         end
`endif
         else begin
            // One token goes out per cycle while anything is owed and hold is low.
            e = (!ih && (ia || owed[k] > 0)) ? 1 : 0;
            t = owed[k] + (ia ? fac[k] : 0) - e;
            if (t > cap[k]) begin
               mov[k] = 1;
`ifdef TOKEN_MULTIPLIER_HALT_ON_OVERFLOW_EN
               owed[k] = 0; mb[k] = 0;
`else
               owed[k] = cap[k]; mb[k] = e;
`endif
            end else begin
               owed[k] = t; mb[k] = e;
            end
         end
      end
   endtask

   task automatic step(input logic na, input logic nh, input logic nr);
      a = na; hold = nh; rst = nr;
      @(posedge clk);
      model_edge(na, nh, nr);
      @(negedge clk);
   endtask

   task automatic grab();
      gb[0] = int'(b_f2); go[0] = int'(ov_f2); gl[0] = int'(bl_f2); gi[0] = int'(idle_f2);
      gb[1] = int'(b_f3); go[1] = int'(ov_f3); gl[1] = int'(bl_f3); gi[1] = int'(idle_f3);
      gb[2] = int'(b_f1); go[2] = int'(ov_f1); gl[2] = int'(bl_f1); gi[2] = int'(idle_f1);
   endtask

   task automatic test_reset();
      step(1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      grab();
      for (int k = 0; k < 3; k++) begin
         checks++; if (gb[k] !== 0) begin errors++; $display("FAIL reset_b[%0d]: got %0d expected 0", k, gb[k]); end
         checks++; if (go[k] !== 0) begin errors++; $display("FAIL reset_overflow[%0d]: got %0d expected 0", k, go[k]); end
         checks++; if (gl[k] !== 0) begin errors++; $display("FAIL reset_backlog[%0d]: got %0d expected 0", k, gl[k]); end
         checks++; if (gi[k] !== 1) begin errors++; $display("FAIL reset_idle[%0d]: got %0d expected 1", k, gi[k]); end
      end
   endtask

   task automatic test_pattern();
      logic [25:0] pa;
      logic [25:0] pb;
      pa = 26'b10010011000110100001100100;
      pb = 26'b11011011110111111001111110;
      step(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 26; i++) begin
         step(pa[25-i], 1'b0, 1'b0);
         checks++; if (b_f2 !== pb[25-i]) begin errors++; $display("FAIL pattern_b cycle %0d: got %0b expected %0b", i, b_f2, pb[25-i]); end
         checks++; if (ov_f2 !== 1'b0) begin errors++; $display("FAIL pattern_overflow cycle %0d: got %0b expected 0", i, ov_f2); end
         checks++; if (int'(bl_f2) !== owed[0]) begin errors++; $display("FAIL pattern_backlog cycle %0d: got %0d expected %0d", i, bl_f2, owed[0]); end
      end
   endtask

   task automatic test_single_f3();
      int eb[4] = '{1, 1, 1, 0};
      int el[4] = '{2, 1, 0, 0};
      int ei[4] = '{0, 0, 1, 1};
      step(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         step((i == 0), 1'b0, 1'b0);
         checks++; if (int'(b_f3) !== eb[i]) begin errors++; $display("FAIL f3_single_b cycle %0d: got %0d expected %0d", i, b_f3, eb[i]); end
         checks++; if (int'(bl_f3) !== el[i]) begin errors++; $display("FAIL f3_single_backlog cycle %0d: got %0d expected %0d", i, bl_f3, el[i]); end
         checks++; if (int'(idle_f3) !== ei[i]) begin errors++; $display("FAIL f3_single_idle cycle %0d: got %0d expected %0d", i, idle_f3, ei[i]); end
      end
   endtask

   task automatic test_run_limit();
      int ones = 0;
      int peak = 0;
      step(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 200; i++) begin
         step(1'b1, 1'b0, 1'b0);
         ones += int'(b_f2);
         if (int'(bl_f2) > peak) peak = int'(bl_f2);
      end
      for (int i = 0; i < 210; i++) begin
         step(1'b0, 1'b0, 1'b0);
         ones += int'(b_f2);
      end
      checks++; if (ones !== 400) begin errors++; $display("FAIL run200_ones: got %0d expected 400", ones); end
      checks++; if (peak !== 200) begin errors++; $display("FAIL run200_peak: got %0d expected 200", peak); end
      checks++; if (ov_f2 !== 1'b0) begin errors++; $display("FAIL run200_overflow: got %0b expected 0", ov_f2); end
      checks++; if (idle_f2 !== 1'b1) begin errors++; $display("FAIL run200_idle: got %0b expected 1", idle_f2); end

      step(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 200; i++) step(1'b1, 1'b0, 1'b0);
      checks++; if (ov_f2 !== 1'b0) begin errors++; $display("FAIL run201_pre_overflow: got %0b expected 0", ov_f2); end
      step(1'b1, 1'b0, 1'b0);
      checks++; if (ov_f2 !== 1'b1) begin errors++; $display("FAIL run201_overflow: got %0b expected 1", ov_f2); end
`ifdef TOKEN_MULTIPLIER_HALT_ON_OVERFLOW_EN
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'b0, 1'b0);
         checks++; if (b_f2 !== 1'b0) begin errors++; $display("FAIL halt_b cycle %0d: got %0b expected 0", i, b_f2); end
         checks++; if (bl_f2 !== 8'd0) begin errors++; $display("FAIL halt_backlog cycle %0d: got %0d expected 0", i, bl_f2); end
      end
`else
      checks++; if (bl_f2 !== 8'd200) begin errors++; $display("FAIL run201_saturate: got %0d expected 200", bl_f2); end
`endif
      for (int i = 0; i < 500; i++) step(1'b0, 1'b0, 1'b0);
      checks++; if (ov_f2 !== 1'b1) begin errors++; $display("FAIL run201_sticky: got %0b expected 1", ov_f2); end
   endtask

   task automatic test_hold();
      step(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b1, 1'b0);
         checks++; if (b_f2 !== 1'b0) begin errors++; $display("FAIL hold_b cycle %0d: got %0b expected 0", i, b_f2); end
      end
      checks++; if (bl_f2 !== 8'd6) begin errors++; $display("FAIL hold_backlog: got %0d expected 6", bl_f2); end
      checks++; if (ov_f2 !== 1'b0) begin errors++; $display("FAIL hold_overflow_f2: got %0b expected 0", ov_f2); end
      checks++; if (ov_f1 !== 1'b1) begin errors++; $display("FAIL hold_overflow_f1: got %0b expected 1", ov_f1); end
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b0, 1'b0);
         checks++; if (b_f2 !== (i < 6)) begin errors++; $display("FAIL hold_drain_b cycle %0d: got %0b expected %0b", i, b_f2, (i < 6)); end
      end
      checks++; if (idle_f2 !== 1'b1) begin errors++; $display("FAIL hold_drain_idle: got %0b expected 1", idle_f2); end
   endtask

   task automatic test_mid_drain_rst();
      step(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 201; i++) step(1'b1, 1'b0, 1'b0);
`ifndef TOKEN_MULTIPLIER_HALT_ON_OVERFLOW_EN
      for (int i = 0; i < 300 && owed[0] != 5; i++) step(1'b0, 1'b0, 1'b0);
      checks++; if (bl_f2 !== 8'd5) begin errors++; $display("FAIL middrain_backlog: got %0d expected 5", bl_f2); end
`endif
      checks++; if (ov_f2 !== 1'b1) begin errors++; $display("FAIL middrain_overflow: got %0b expected 1", ov_f2); end
      step(1'b0, 1'b0, 1'b1);
      checks++; if (b_f2 !== 1'b0) begin errors++; $display("FAIL middrain_rst_b: got %0b expected 0", b_f2); end
      checks++; if (bl_f2 !== 8'd0) begin errors++; $display("FAIL middrain_rst_backlog: got %0d expected 0", bl_f2); end
      checks++; if (idle_f2 !== 1'b1) begin errors++; $display("FAIL middrain_rst_idle: got %0b expected 1", idle_f2); end
      checks++; if (ov_f2 !== 1'b0) begin errors++; $display("FAIL middrain_rst_overflow: got %0b expected 0", ov_f2); end
      step(1'b1, 1'b0, 1'b0);
      checks++; if (b_f2 !== 1'b1 || bl_f2 !== 8'd1) begin errors++; $display("FAIL postrst_t1: got b=%0b backlog=%0d expected b=1 backlog=1", b_f2, bl_f2); end
      step(1'b0, 1'b0, 1'b0);
      checks++; if (b_f2 !== 1'b1 || bl_f2 !== 8'd0) begin errors++; $display("FAIL postrst_t2: got b=%0b backlog=%0d expected b=1 backlog=0", b_f2, bl_f2); end
      step(1'b0, 1'b0, 1'b0);
      checks++; if (b_f2 !== 1'b0) begin errors++; $display("FAIL postrst_t3: got b=%0b expected 0", b_f2); end
   endtask

   task automatic test_random();
      step(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 600; i++) begin
         logic na, nh, nr;
         na = ($urandom_range(0, 99) < 55);
         nh = ($urandom_range(0, 99) < 25);
         nr = ($urandom_range(0, 199) == 0);
         step(na, nh, nr);
         grab();
         for (int k = 0; k < 3; k++) begin
            checks++; if (gb[k] !== mb[k]) begin errors++; $display("FAIL random_b[%0d] cycle %0d: got %0d expected %0d", k, i, gb[k], mb[k]); end
            checks++; if (go[k] !== mov[k]) begin errors++; $display("FAIL random_overflow[%0d] cycle %0d: got %0d expected %0d", k, i, go[k], mov[k]); end
            checks++; if (gl[k] !== owed[k]) begin errors++; $display("FAIL random_backlog[%0d] cycle %0d: got %0d expected %0d", k, i, gl[k], owed[k]); end
            checks++; if (gi[k] !== int'(owed[k] == 0)) begin errors++; $display("FAIL random_idle[%0d] cycle %0d: got %0d expected %0d", k, i, gi[k], int'(owed[k] == 0)); end
         end
      end
   endtask

   initial begin
      a = 1'b0; hold = 1'b0; rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         owed[k] = 0; mb[k] = 0; mov[k] = 0;
      end
      test_reset();
      test_pattern();
      test_single_f3();
      test_run_limit();
      test_hold();
      test_mid_drain_rst();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
